// File: rtl/video_pattern_pkg.sv
// Shared encoding and palette for the video pattern checker.
// Colour states S1..S8 are encoded 0..7 so the pair, band and page moves reduce to bit operations.
package video_pattern_pkg;

    typedef enum logic [2:0] {
        S1 = 3'd0, S2 = 3'd1, S3 = 3'd2, S4 = 3'd3,
        S5 = 3'd4, S6 = 3'd5, S7 = 3'd6, S8 = 3'd7
    } color_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ctrl_state_t;

    localparam logic [23:0] PAL_S1 = {8'd142, 8'd68,  8'd173};
    localparam logic [23:0] PAL_S2 = {8'd44,  8'd62,  8'd80};
    localparam logic [23:0] PAL_S3 = {8'd22,  8'd160, 8'd133};
    localparam logic [23:0] PAL_S4 = {8'd41,  8'd128, 8'd185};
    localparam logic [23:0] PAL_S5 = {8'd26,  8'd188, 8'd156};
    localparam logic [23:0] PAL_S6 = {8'd230, 8'd126, 8'd34};
    localparam logic [23:0] PAL_S7 = {8'd241, 8'd196, 8'd15};
    localparam logic [23:0] PAL_S8 = {8'd46,  8'd204, 8'd113};

    localparam logic [7:0] LFSR_SEED = 8'h01;

    function automatic logic [23:0] palette(input color_state_t s);
        case (s)
            S1:      palette = PAL_S1;
            S2:      palette = PAL_S2;
            S3:      palette = PAL_S3;
            S4:      palette = PAL_S4;
            S5:      palette = PAL_S5;
            S6:      palette = PAL_S6;
            S7:      palette = PAL_S7;
            default: palette = PAL_S8;
        endcase
    endfunction

    // Segment end: swap within the pair.
    function automatic color_state_t pair_next(input color_state_t s);
        pair_next = color_state_t'({s[2], s[1], ~s[0]});
    endfunction

    // Band end: jump to the first state of the other pair in the same half.
    function automatic color_state_t band_next(input color_state_t s);
        band_next = color_state_t'({s[2], ~s[1], 1'b0});
    endfunction

    // Page end: jump to the first state of the other half.
    function automatic color_state_t page_next(input color_state_t s);
        page_next = color_state_t'({~s[2], 2'b00});
    endfunction

endpackage

// File: rtl/pattern_model.sv
// Expected-colour model: steps once per accepted pixel through segment, band and page boundaries.
module pattern_model
    import video_pattern_pkg::*;
#(
    parameter int SEG_LEN       = 80,
    parameter int SEGS_PER_BAND = 500,
    parameter int PAGE_PIXELS   = 34560000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [23:0] expected,
    output logic        page_end
);

    localparam int PIX_W  = (SEG_LEN > 1)       ? $clog2(SEG_LEN)       : 1;
    localparam int SEG_W  = (SEGS_PER_BAND > 1) ? $clog2(SEGS_PER_BAND) : 1;
    localparam int PAGE_W = (PAGE_PIXELS > 1)   ? $clog2(PAGE_PIXELS)   : 1;

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(SEG_LEN - 1);
    localparam logic [SEG_W-1:0]  SEG_LAST  = SEG_W'(SEGS_PER_BAND - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGE_PIXELS - 1);

    color_state_t      color;
    logic [PIX_W-1:0]  pix_cnt;
    logic [SEG_W-1:0]  seg_cnt;
    logic [PAGE_W-1:0] page_cnt;
    logic              last_pix;
    logic              last_seg;
    logic              last_page;

    assign last_pix  = (pix_cnt == PIX_LAST);
    assign last_seg  = (seg_cnt == SEG_LAST);
    assign last_page = (page_cnt == PAGE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            color    <= S1;
            pix_cnt  <= '0;
            seg_cnt  <= '0;
            page_cnt <= '0;
        end else if (advance) begin
            if (last_page) begin
                // Page end wins over segment and band rules.
                color    <= page_next(color);
                pix_cnt  <= '0;
                seg_cnt  <= '0;
                page_cnt <= '0;
            end else begin
                page_cnt <= page_cnt + 1'b1;
                if (last_pix) begin
                    pix_cnt <= '0;
                    if (last_seg) begin
                        seg_cnt <= '0;
                        color   <= band_next(color);
                    end else begin
                        seg_cnt <= seg_cnt + 1'b1;
                        color   <= pair_next(color);
                    end
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
        end
    end

    assign expected = palette(color);
    assign page_end = advance && last_page;

endmodule

// File: rtl/video_pattern_checker.sv
// Checks an incoming RGB pixel stream against the colour-bar pattern and counts mismatches.
// Optional VideoReady throttling by an 8-bit LFSR is built when VIDEO_CHECKER_THROTTLE_EN is defined.
module video_pattern_checker
    import video_pattern_pkg::*;
#(
    parameter int          SEG_LEN       = 80,
    parameter int          SEGS_PER_BAND = 500,
    parameter int          PAGE_PIXELS   = 34560000,
    parameter logic [15:0] MAX_ERRORS    = 16'hFFFF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [23:0] Video,
    output logic        VideoReady,
    output logic        Mismatch,
    output logic [15:0] ErrorCount,
    output logic        PageDone,
    output logic        Halted
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic        accept;
    logic        pix_bad;
    logic [15:0] err_next;
    logic        ready_next;
    logic        permit;
    logic [23:0] expected;
    logic        page_end;

    assign accept   = VideoReady;
    assign pix_bad  = accept && (Video != expected);
    assign err_next = (pix_bad && ErrorCount != 16'hFFFF) ? ErrorCount + 16'd1 : ErrorCount;

`ifdef VIDEO_CHECKER_THROTTLE_EN
    logic [7:0] lfsr;

    always_ff @(posedge Clock) begin
        if (Reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign permit = lfsr[0];
`else
    assign permit = 1'b1;
`endif

    pattern_model #(
        .SEG_LEN       (SEG_LEN),
        .SEGS_PER_BAND (SEGS_PER_BAND),
        .PAGE_PIXELS   (PAGE_PIXELS)
    ) u_model (
        .clk      (Clock),
        .rst      (Reset),
        .advance  (accept),
        .expected (expected),
        .page_end (page_end)
    );

    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // The halt decision uses the post-increment count so no further pixel is taken after the limit.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (Enable) state_next = ST_RUN;
            ST_RUN: begin
                if (err_next >= MAX_ERRORS) state_next = ST_HALT;
                else if (!Enable)           state_next = ST_IDLE;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_next = (state_next == ST_RUN) && Enable && permit;
        Halted     = (state == ST_HALT);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            VideoReady <= 1'b0;
            Mismatch   <= 1'b0;
            ErrorCount <= 16'd0;
            PageDone   <= 1'b0;
        end else begin
            VideoReady <= ready_next;
            Mismatch   <= pix_bad;
            ErrorCount <= err_next;
            PageDone   <= page_end;
        end
    end

endmodule

// File: doc/video_pattern_checker.md
VIDEO_PATTERN_CHECKER -- requirements
Module: video_pattern_checker

Interface
REQ-001 SHALL have parameter SEG_LEN, default 80, pixels per colour segment.
REQ-002 SHALL have parameter SEGS_PER_BAND, default 500, segments per band.
REQ-003 SHALL have parameter PAGE_PIXELS, default 34560000, pixels per page; PAGE_PIXELS SHALL be a multiple of SEG_LEN*SEGS_PER_BAND.
REQ-004 SHALL have parameter MAX_ERRORS, default 16'hFFFF, mismatch count that halts checking.
REQ-005 SHALL have ports: Clock  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: Reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: Enable  in  1  allows pixel acceptance; Video  in  24  {R,G,B} pixel from source.
REQ-008 SHALL have ports: VideoReady  out  1  registered; Mismatch  out  1  one-cycle error pulse; ErrorCount  out  16.
REQ-009 SHALL have ports: PageDone  out  1  one-cycle pulse; Halted  out  1  sticky stop flag.

Function
REQ-010 SHALL accept one pixel on every Clock edge where VideoReady is 1; Video is valid whenever VideoReady is high.
REQ-011 SHALL model the expected colour with 8 states S1..S8 and palette S1 {142,68,173}, S2 {44,62,80}, S3 {22,160,133}, S4 {41,128,185}, S5 {26,188,156}, S6 {230,126,34}, S7 {241,196,15}, S8 {46,204,113}.
REQ-012 SHALL advance the model only on accepted pixels: after SEG_LEN pixels, toggle within pair (S1<->S2, S3<->S4, S5<->S6, S7<->S8).
REQ-013 SHALL, on the segment that completes a band (SEGS_PER_BAND segments), move to the other pair of the same half instead: {S1,S2}->S3, {S3,S4}->S1, {S5,S6}->S7, {S7,S8}->S5.
REQ-014 SHALL, on the pixel that completes a page (PAGE_PIXELS pixels), go to S5 from S1..S4 or to S1 from S5..S8, clear segment and band counters, and pulse PageDone the next cycle; page end overrides segment and band rules.
REQ-015 SHALL compare each accepted Video to the expected palette value and pulse Mismatch 1 cycle after an accepted mismatch.
REQ-016 SHALL increment ErrorCount (saturating at 16'hFFFF) in the same cycle Mismatch is asserted.
REQ-017 SHALL implement FSM IDLE, RUN, HALT: IDLE->RUN when Enable=1; RUN->IDLE when Enable=0; RUN->HALT when ErrorCount reaches MAX_ERRORS; HALT exits only on Reset.
REQ-018 SHALL drive VideoReady registered: 1 only in RUN with Enable=1 (and throttle permit, REQ-024); 0 in IDLE and HALT.
REQ-019 SHALL retain model state across IDLE periods; no pixel is consumed while VideoReady=0.
REQ-020 SHALL assert Halted in HALT; the model does not advance and counts freeze.

Reset
REQ-021 SHALL on Reset set FSM IDLE, model S1, all counters 0, VideoReady 0, Mismatch 0, PageDone 0, ErrorCount 0, Halted 0.
REQ-022 SHALL give Reset priority over every other event, including a mid-page accepted pixel in the same cycle.

Configuration
REQ-023 SHALL support macro VIDEO_CHECKER_THROTTLE_EN.
REQ-024 SHALL, with the macro defined, gate VideoReady with bit 0 of an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01 on Reset, steps every cycle); without it, the permit is constant 1.

Structure
REQ-025 SHALL place palette constants and the S1..S8 encoding in shared package video_pattern_pkg.
REQ-026 SHALL implement the expected-colour model as sub-module pattern_model (inputs: advance strobe; output: expected 24-bit colour).

Verification (SEG_LEN=4, SEGS_PER_BAND=2, PAGE_PIXELS=32, macro off unless stated)
REQ-027 Conforming source, Enable=1 for 64 accepted pixels -> colours S1x4,S2x4,S3x4,S4x4,S1x4.. then S5 at pixel 32; PageDone pulses twice; ErrorCount=0.
REQ-028 Corrupt pixel 5 to 24'h000000 -> Mismatch pulse 1 cycle later; ErrorCount=1; later pixels still checked against correct sequence.
REQ-029 Enable low for 10 cycles after pixel 6 -> VideoReady 0 one cycle later; resume expects S2 at pixel 7; no errors.
REQ-030 MAX_ERRORS=3, constant wrong pixels -> Halted=1 after 3rd mismatch, VideoReady 0, ErrorCount holds 3 until Reset.
REQ-031 Reset asserted at pixel 13 -> all outputs at reset values next cycle; restart expects S1.
REQ-032 Macro defined, conforming source driven only on VideoReady -> VideoReady follows LFSR pattern from seed 8'h01; 32 accepted pixels still yield exactly one PageDone, zero errors.
